// File: rtl/multi_timer.sv
// ---------------------------------------------------------------------------
// multi_timer
//   N_CH independent compare timers behind a small register slot.
//   Each channel has a W-bit up-counter, a 32-bit compare period, a control
//   register (go / mode / ie / flag) and, for W > 32, a shadow register that
//   captures count[W-1:32] whenever count[31:0] is read.
//
//   Per-channel word map (addr[4:2] = channel, addr[1:0] = register):
//     0 count[31:0] (RO)   1 shadow (RO)   2 ctrl (RW)   3 period (RW)
//   ctrl write: [0] go, [1] clear count, [2] mode (1 = periodic), [3] ie,
//               [4] clear flag (write-1-to-clear)
//   ctrl read : {27'b0, flag, ie, mode, 1'b0, go}
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   asynchronous reset, active low
//   cs       in   slot chip select
//   read     in   read strobe (qualified by cs)
//   write    in   write strobe (qualified by cs)
//   addr     in   [4:0] word address
//   wr_data  in   [31:0] write data
//   rd_data  out  [31:0] combinational read data
//   tick     out  [N_CH-1:0] one-cycle pulse per channel on a compare event
//   irq      out  OR over channels of (flag & ie)
// ---------------------------------------------------------------------------
module multi_timer #(
  parameter int N_CH = 4,
  parameter int W    = 48
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cs,
  input  logic            read,
  input  logic            write,
  input  logic [4:0]      addr,
  input  logic [31:0]     wr_data,
  output logic [31:0]     rd_data,
  output logic [N_CH-1:0] tick,
  output logic            irq
);

  // Compare is done at max(W,32) bits so a period wider than the counter
  // simply never matches.
  localparam int CW = (W > 32) ? W : 32;

  logic [2:0] ch_sel;
  logic [1:0] reg_sel;

  assign ch_sel  = addr[4:2];
  assign reg_sel = addr[1:0];

  // Read views sized to the full 3-bit channel space; unpopulated channels
  // are tied to zero so out-of-range reads return 0 without a range check.
  logic [31:0] cnt_lo_a [8];
  logic [31:0] shd_a    [8];
  logic [31:0] ctrl_a   [8];
  logic [31:0] per_a    [8];

  logic [N_CH-1:0] flag_v;
  logic [N_CH-1:0] ie_v;

  generate
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
      logic [W-1:0]  count_q;
      logic [W-1:0]  count_d;
      logic [31:0]   period_q;
      logic          go_q;
      logic          go_d;
      logic          mode_q;
      logic          ie_q;
      logic          flag_q;
      logic          flag_d;
      logic          tick_q;
      logic          sel;
      logic          ctrl_wr;
      logic          per_wr;
      logic          clr;
      logic          evt;
      logic [CW-1:0] cnt_x;

      assign sel     = cs && (ch_sel == 3'(c));
      assign ctrl_wr = sel && write && (reg_sel == 2'd2);
      assign per_wr  = sel && write && (reg_sel == 2'd3);
      assign clr     = ctrl_wr && wr_data[1];

      assign cnt_x = CW'(count_q);
      // A clear in the same cycle suppresses the event entirely.
      assign evt   = go_q && (period_q != 32'd0) && (cnt_x == CW'(period_q)) && !clr;

      always_comb begin
        count_d = count_q;
        if (clr) begin
          count_d = '0;
        end else if (evt) begin
          // Periodic restarts from 0; one-shot holds at the period value.
          if (mode_q) count_d = '0;
        end else if (go_q) begin
          count_d = count_q + W'(1);
        end
      end

      // A ctrl write of go wins over the one-shot self-stop.
      always_comb begin
        go_d = go_q;
        if (ctrl_wr)              go_d = wr_data[0];
        else if (evt && !mode_q)  go_d = 1'b0;
      end

      // Event beats a simultaneous write-1-to-clear.
      always_comb begin
        flag_d = flag_q;
        if (evt)                          flag_d = 1'b1;
        else if (ctrl_wr && wr_data[4])   flag_d = 1'b0;
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          count_q  <= '0;
          period_q <= '0;
          go_q     <= 1'b0;
          mode_q   <= 1'b0;
          ie_q     <= 1'b0;
          flag_q   <= 1'b0;
          tick_q   <= 1'b0;
        end else begin
          count_q <= count_d;
          go_q    <= go_d;
          flag_q  <= flag_d;
          tick_q  <= evt;
          if (ctrl_wr) begin
            mode_q <= wr_data[2];
            ie_q   <= wr_data[3];
          end
          if (per_wr) period_q <= wr_data;
        end
      end

      if (W > 32) begin : g_shadow
        logic          cnt_rd;
        logic [W-33:0] shadow_q;

        // Reading count[31:0] freezes the upper bits so a following
        // shadow read gives a coherent W-bit value.
        assign cnt_rd = sel && read && (reg_sel == 2'd0);

        always_ff @(posedge clk or negedge reset) begin
          if (!reset)      shadow_q <= '0;
          else if (cnt_rd) shadow_q <= count_q[W-1:32];
        end

        assign shd_a[c] = 32'(shadow_q);
      end else begin : g_no_shadow
        assign shd_a[c] = '0;
      end

      assign cnt_lo_a[c] = cnt_x[31:0];
      assign ctrl_a[c]   = {27'b0, flag_q, ie_q, mode_q, 1'b0, go_q};
      assign per_a[c]    = period_q;
      assign tick[c]     = tick_q;
      assign flag_v[c]   = flag_q;
      assign ie_v[c]     = ie_q;
    end

    for (genvar c = N_CH; c < 8; c++) begin : g_unused
      assign cnt_lo_a[c] = '0;
      assign shd_a[c]    = '0;
      assign ctrl_a[c]   = '0;
      assign per_a[c]    = '0;
    end
  endgenerate

  assign irq = |(flag_v & ie_v);

  always_comb begin
    rd_data = '0;
    if (reset) begin
      case (reg_sel)
        2'd0:    rd_data = cnt_lo_a[ch_sel];
        2'd1:    rd_data = shd_a[ch_sel];
        2'd2:    rd_data = ctrl_a[ch_sel];
        default: rd_data = per_a[ch_sel];
      endcase
    end
  end

endmodule

// File: tb/tb_multi_timer.sv
// ---------------------------------------------------------------------------
// tb_multi_timer
//   Directed bench for multi_timer (N_CH=4, W=48): a register-access vector
//   table followed by hand-written multi-cycle sequences.
// ---------------------------------------------------------------------------
module tb_multi_timer;

  localparam int N_CH = 4;
  localparam int W    = 48;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            cs = 1'b0;
  logic            read = 1'b0;
  logic            write = 1'b0;
  logic [4:0]      addr = '0;
  logic [31:0]     wr_data = '0;
  logic [31:0]     rd_data;
  logic [N_CH-1:0] tick;
  logic            irq;

  int n_chk  = 0;
  int n_fail = 0;
  int n_tick = 0;

  typedef struct {
    logic        is_wr;
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [18];

  always #5 clk = ~clk;

  multi_timer #(.N_CH(N_CH), .W(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs),
    .read    (read),
    .write   (write),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .tick    (tick),
    .irq     (irq)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at (or just after) a falling edge; the write lands on the next
  // rising edge and the task returns at the following falling edge.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; read = 1'b0; addr = a; wr_data = d;
    @(negedge clk);
    write = 1'b0; cs = 1'b0; wr_data = '0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
    cs = 1'b1; read = 1'b1; write = 1'b0; addr = a;
    #1;
    chk(name, rd_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1'b1, 5'h0B, 32'h1234_5678, 32'h0};
    vt[1]  = '{1'b0, 5'h0B, 32'h0,         32'h1234_5678};
    vt[2]  = '{1'b1, 5'h0A, 32'h0000_000C, 32'h0};
    vt[3]  = '{1'b0, 5'h0A, 32'h0,         32'h0000_000C};
    vt[4]  = '{1'b1, 5'h0A, 32'hFFFF_FFEE, 32'h0};
    vt[5]  = '{1'b0, 5'h0A, 32'h0,         32'h0000_000C};
    vt[6]  = '{1'b1, 5'h08, 32'h0000_FFFF, 32'h0};
    vt[7]  = '{1'b0, 5'h08, 32'h0,         32'h0};
    vt[8]  = '{1'b1, 5'h09, 32'h0000_FFFF, 32'h0};
    vt[9]  = '{1'b0, 5'h09, 32'h0,         32'h0};
    vt[10] = '{1'b1, 5'h1F, 32'h0000_AAAA, 32'h0};
    vt[11] = '{1'b0, 5'h1F, 32'h0,         32'h0};
    vt[12] = '{1'b0, 5'h16, 32'h0,         32'h0};
    vt[13] = '{1'b0, 5'h0F, 32'h0,         32'h0};
    vt[14] = '{1'b0, 5'h0B, 32'h0,         32'h1234_5678};
    vt[15] = '{1'b1, 5'h0A, 32'h0,         32'h0};
    vt[16] = '{1'b1, 5'h0B, 32'h0,         32'h0};
    vt[17] = '{1'b0, 5'h0A, 32'h0,         32'h0};

    // Reset state
    repeat (2) @(negedge clk);
    rd(5'h00, 32'h0, "rst_count0");
    rd(5'h0A, 32'h0, "rst_ctrl2");
    rd(5'h0F, 32'h0, "rst_period3");
    chk("rst_tick", tick, 4'b0000);
    chk("rst_irq", irq, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Register access table (all channels stopped)
    for (int k = 0; k < 18; k++) begin
      if (vt[k].is_wr) wr(vt[k].a, vt[k].d);
      else             rd(vt[k].a, vt[k].exp, $sformatf("vec%0d", k));
    end
    chk("table_irq", irq, 1'b0);

    // Ch0 periodic, period 4: count 0..4 repeating, tick every 5 cycles
    @(negedge clk);
    wr(5'h03, 32'd4);
    wr(5'h02, 32'h0D);
    for (int i = 0; i < 13; i++) begin
      rd(5'h00, 32'(i % 5), $sformatf("ch0_count_%0d", i));
      chk($sformatf("ch0_tick_%0d", i), tick, ((i % 5 == 0) && (i > 0)) ? 4'b0001 : 4'b0000);
      chk($sformatf("ch0_irq_%0d", i), irq, (i >= 5));
      @(negedge clk);
    end
    wr(5'h02, 32'h1D);
    chk("ch0_w1c_irq", irq, 1'b0);
    wr(5'h02, 32'h12);
    rd(5'h00, 32'h0, "ch0_stopped_count");
    rd(5'h02, 32'h0, "ch0_stopped_ctrl");

    // Ch1 one-shot, period 3: stops at 3, single tick
    @(negedge clk);
    wr(5'h07, 32'd3);
    wr(5'h06, 32'h01);
    n_tick = 0;
    for (int i = 0; i < 10; i++) begin
      rd(5'h04, (i < 3) ? 32'(i) : 32'd3, $sformatf("ch1_count_%0d", i));
      chk($sformatf("ch1_tick_%0d", i), tick, (i == 4) ? 4'b0010 : 4'b0000);
      if (tick[1]) n_tick++;
      @(negedge clk);
    end
    chk("ch1_tick_total", n_tick, 1);
    rd(5'h06, 32'h10, "ch1_ctrl");
    chk("ch1_irq", irq, 1'b0);

    // Ch2: clear collides with periodic match, then flag-clear collides with event
    @(negedge clk);
    wr(5'h0B, 32'd2);
    wr(5'h0A, 32'h05);
    @(negedge clk);
    @(negedge clk);
    rd(5'h08, 32'd2, "ch2_pre_clr");
    wr(5'h0A, 32'h07);
    rd(5'h08, 32'd0, "ch2_clr_count");
    chk("ch2_clr_tick", tick, 4'b0000);
    rd(5'h0A, 32'h05, "ch2_clr_flag");
    @(negedge clk);
    @(negedge clk);
    rd(5'h08, 32'd2, "ch2_pre_w1c");
    wr(5'h0A, 32'h15);
    chk("ch2_w1c_tick", tick, 4'b0100);
    rd(5'h0A, 32'h15, "ch2_event_wins");
    wr(5'h0A, 32'h12);

    // Ch3 one-shot, go rewritten in the event cycle
    wr(5'h0F, 32'd1);
    wr(5'h0E, 32'h01);
    @(negedge clk);
    wr(5'h0E, 32'h01);
    rd(5'h0E, 32'h11, "ch3_go_override");
    chk("ch3_tick_a", tick, 4'b1000);
    @(negedge clk);
    rd(5'h0E, 32'h10, "ch3_oneshot_stop");
    chk("ch3_tick_b", tick, 4'b1000);

    // Ch3 period 0: free run, no tick
    wr(5'h0E, 32'h12);
    wr(5'h0F, 32'd0);
    wr(5'h0E, 32'h05);
    for (int i = 0; i < 8; i++) begin
      rd(5'h0C, 32'(i), $sformatf("ch3_free_%0d", i));
      chk($sformatf("ch3_free_tick_%0d", i), tick, 4'b0000);
      @(negedge clk);
    end

    // Channel 7 does not exist: writes ignored, reads 0, others untouched
    wr(5'h1E, 32'h05);
    wr(5'h1F, 32'd3);
    rd(5'h1E, 32'h0, "ch7_ctrl");
    rd(5'h1F, 32'h0, "ch7_period");
    rd(5'h06, 32'h10, "ch1_ctrl_kept");
    rd(5'h07, 32'd3, "ch1_period_kept");
    rd(5'h0B, 32'd2, "ch2_period_kept");
    rd(5'h02, 32'h0, "ch0_ctrl_kept");

    // Ch0 upper-word shadow: preload count near 2^32 (cannot be reached by running)
    force dut.g_ch[0].count_q = 48'h1_0000_0003;
    @(negedge clk);
    release dut.g_ch[0].count_q;
    wr(5'h02, 32'h01);
    rd(5'h00, 32'd3, "ch0_preload");
    @(negedge clk);
    @(negedge clk);
    rd(5'h00, 32'd5, "ch0_low_word");
    chk("ch0_wide_no_tick", tick[0], 1'b0);
    @(negedge clk);
    rd(5'h01, 32'd1, "ch0_shadow");
    @(negedge clk);
    rd(5'h00, 32'd7, "ch0_still_running");

    // Reset mid-run
    wr(5'h0B, 32'd1);
    wr(5'h0A, 32'h0D);
    repeat (3) @(negedge clk);
    chk("pre_rst_irq", irq, 1'b1);
    #2;
    reset = 1'b0;
    cs = 1'b1; read = 1'b1; addr = 5'h0C;
    #1;
    chk("rst_async_rd", rd_data, 32'h0);
    chk("rst_async_tick", tick, 4'b0000);
    chk("rst_async_irq", irq, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cs = 1'b0; read = 1'b0;
    repeat (3) @(negedge clk);
    for (int c = 0; c < N_CH; c++) begin
      rd(5'(c * 4),     32'h0, $sformatf("post_rst_count%0d", c));
      rd(5'(c * 4 + 2), 32'h0, $sformatf("post_rst_ctrl%0d", c));
      rd(5'(c * 4 + 3), 32'h0, $sformatf("post_rst_period%0d", c));
    end
    chk("post_rst_irq", irq, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
